axi_stream_decompressor: RTL

//  Byte-oriented run-length decoder: inverse of the compressor's token format. Sits between the
//  DMA read channel and the consumer of restored record data. Unpacks 8-byte AXI-Stream input

---
 rtl/axi_stream_decompressor.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_decompressor.sv
`default_nettype none
// axi_stream_decompressor: run-length token decoder between 8-byte AXI-Stream ports, Rev 1.0.
// Define DECOMP_STATS_EN to add the statsBytesIn/statsBytesOut counters.
module axi_stream_decompressor #(
  parameter int DATA_BUS_WIDTH_BYTES = 8,
  parameter int MIN_RUN_LENGTH       = 3,
  parameter int STATS_WIDTH          = 32
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [8*DATA_BUS_WIDTH_BYTES-1:0] dataIn_tdata,
  input  logic                              dataIn_tvalid,
  input  logic [DATA_BUS_WIDTH_BYTES-1:0]   dataIn_tstrb,
  input  logic                              dataIn_tlast,
  output logic                              dataIn_tready,
  output logic [8*DATA_BUS_WIDTH_BYTES-1:0] dataOut_tdata,
  output logic                              dataOut_tvalid,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]   dataOut_tstrb,
  output logic                              dataOut_tlast,
  input  logic                              dataOut_tready,
`ifdef DECOMP_STATS_EN
  output logic [STATS_WIDTH-1:0]            statsBytesIn,
  output logic [STATS_WIDTH-1:0]            statsBytesOut,
`endif
  output logic                              decodeError
);

  localparam int DBW = DATA_BUS_WIDTH_BYTES;
  localparam int CW  = $clog2(DBW + 1);
  localparam logic [CW-1:0] PK_FULL = CW'(DBW);

  if (STATS_WIDTH < 1 || MIN_RUN_LENGTH < 1 || MIN_RUN_LENGTH > 128) begin : g_param_check
    $error("axi_stream_decompressor: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_TOKEN    = 3'd0,
    S_LITERAL  = 3'd1,
    S_RUN_VAL  = 3'd2,
    S_RUN_EMIT = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         run_val_q, run_val_d;
  logic               end_pend_q, end_pend_d;
  logic               err_q, err_d;
  logic               rdy_en_q;
  logic [8*DBW-1:0]   in_data_q;
  logic [DBW-1:0]     in_strb_q;
  logic               in_last_q, in_valid_q;
  logic [8*DBW-1:0]   pk_data_q, pk_data_d;
  logic [CW-1:0]      pk_cnt_q, pk_cnt_d;
  logic [8*DBW-1:0]   ho_data_q;
  logic [DBW-1:0]     ho_strb_q;
  logic               ho_last_q, ho_valid_q;

  logic [7:0]         w_byte_in, w_emit_byte;
  logic [DBW-1:0]     w_strb_rest, w_pk_mask;
  logic               w_byte_avail, w_byte_final, w_empty_beat;
  logic               w_consume, w_drop_empty, w_emit, w_flush, w_move;
  logic               w_can_move, w_pk_room, w_in_free, w_in_hs;
  logic [CW-1:0]      w_pk_base;

  // Next byte is the lowest lane still flagged in the remaining strobe mask.
  always_comb begin
    w_byte_in = '0;
    for (int i = DBW - 1; i >= 0; i--) begin
      if (in_strb_q[i]) w_byte_in = in_data_q[8*i +: 8];
    end
  end

  assign w_strb_rest  = in_strb_q & (in_strb_q - 1'b1);
  assign w_byte_avail = in_valid_q && (in_strb_q != '0);
  assign w_byte_final = in_last_q && (w_strb_rest == '0);
  assign w_empty_beat = in_valid_q && (in_strb_q == '0);
  assign w_can_move   = !ho_valid_q || dataOut_tready;
  assign w_pk_room    = (pk_cnt_q != PK_FULL) || w_can_move;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    run_val_d    = run_val_q;
    end_pend_d   = end_pend_q;
    err_d        = 1'b0;
    w_consume    = 1'b0;
    w_drop_empty = 1'b0;
    w_emit       = 1'b0;
    w_emit_byte  = w_byte_in;
    w_flush      = 1'b0;
    case (state_q)
      S_TOKEN: begin
        if (w_byte_avail) begin
          w_consume = 1'b1;
          if (w_byte_in[7]) begin
            state_d = S_RUN_VAL;
            count_d = {1'b0, w_byte_in[6:0]} + 8'(MIN_RUN_LENGTH);
          end else begin
            state_d = S_LITERAL;
            count_d = {1'b0, w_byte_in[6:0]} + 8'd1;
          end
          if (w_byte_final) begin
            err_d   = 1'b1;
            state_d = S_FLUSH;
          end
        end else if (w_empty_beat) begin
          w_drop_empty = 1'b1;
          if (in_last_q) state_d = S_FLUSH;
        end
      end
      S_LITERAL: begin
        if (w_byte_avail) begin
          if (w_pk_room) begin
            w_consume = 1'b1;
            w_emit    = 1'b1;
            count_d   = count_q - 8'd1;
            if (count_q == 8'd1) begin
              state_d = w_byte_final ? S_FLUSH : S_TOKEN;
            end else if (w_byte_final) begin
              err_d   = 1'b1;
              state_d = S_FLUSH;
            end
          end
        end else if (w_empty_beat) begin
          w_drop_empty = 1'b1;
          if (in_last_q) begin
            err_d   = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_RUN_VAL: begin
        if (w_byte_avail) begin
          w_consume  = 1'b1;
          run_val_d  = w_byte_in;
          end_pend_d = w_byte_final;
          state_d    = S_RUN_EMIT;
        end else if (w_empty_beat) begin
          w_drop_empty = 1'b1;
          if (in_last_q) begin
            err_d   = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_RUN_EMIT: begin
        w_emit_byte = run_val_q;
        if (w_pk_room) begin
          w_emit  = 1'b1;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) begin
            state_d    = end_pend_q ? S_FLUSH : S_TOKEN;
            end_pend_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        if (w_can_move) begin
          w_flush = 1'b1;
          state_d = S_TOKEN;
        end
      end
      default: state_d = S_TOKEN;
    endcase
  end

  // A full packer is held back until the next byte or the flush decides its tlast.
  assign w_move    = (w_emit && (pk_cnt_q == PK_FULL)) || w_flush;
  assign w_pk_base = w_move ? '0 : pk_cnt_q;

  always_comb begin
    pk_data_d = w_move ? '0 : pk_data_q;
    pk_cnt_d  = w_pk_base;
    for (int i = 0; i < DBW; i++) begin
      w_pk_mask[i] = (CW'(i) < pk_cnt_q);
      if (w_emit && (w_pk_base == CW'(i))) pk_data_d[8*i +: 8] = w_emit_byte;
    end
    if (w_emit) pk_cnt_d = w_pk_base + 1'b1;
  end

  assign w_in_free     = (w_consume && (w_strb_rest == '0)) || w_drop_empty;
  assign dataIn_tready = rdy_en_q && (!in_valid_q || w_in_free);
  assign w_in_hs       = dataIn_tvalid && dataIn_tready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= S_TOKEN;
      count_q    <= '0;
      run_val_q  <= '0;
      end_pend_q <= 1'b0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      in_data_q  <= '0;
      in_strb_q  <= '0;
      in_last_q  <= 1'b0;
      in_valid_q <= 1'b0;
      pk_data_q  <= '0;
      pk_cnt_q   <= '0;
      ho_data_q  <= '0;
      ho_strb_q  <= '0;
      ho_last_q  <= 1'b0;
      ho_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      run_val_q  <= run_val_d;
      end_pend_q <= end_pend_d;
      err_q      <= err_d;
      rdy_en_q   <= 1'b1;
      if (w_in_hs) begin
        in_data_q  <= dataIn_tdata;
        in_strb_q  <= dataIn_tstrb;
        in_last_q  <= dataIn_tlast;
        in_valid_q <= 1'b1;
      end else begin
        if (w_consume) in_strb_q <= w_strb_rest;
        if (w_in_free) in_valid_q <= 1'b0;
      end
      pk_data_q <= pk_data_d;
      pk_cnt_q  <= pk_cnt_d;
      if (w_move) begin
        ho_data_q  <= pk_data_q;
        ho_strb_q  <= w_pk_mask;
        ho_last_q  <= w_flush;
        ho_valid_q <= 1'b1;
      end else if (dataOut_tready) begin
        ho_valid_q <= 1'b0;
      end
    end
  end

`ifdef DECOMP_STATS_EN
  logic [STATS_WIDTH-1:0] stats_in_q, stats_out_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      stats_in_q  <= '0;
      stats_out_q <= '0;
    end else begin
      if (w_consume && (stats_in_q != '1)) stats_in_q <= stats_in_q + STATS_WIDTH'(1);
      if (w_emit && (stats_out_q != '1)) stats_out_q <= stats_out_q + STATS_WIDTH'(1);
    end
  end

  assign statsBytesIn  = stats_in_q;
  assign statsBytesOut = stats_out_q;
`endif

  assign dataOut_tdata  = ho_data_q;
  assign dataOut_tvalid = ho_valid_q;
  assign dataOut_tstrb  = ho_strb_q;
  assign dataOut_tlast  = ho_last_q;
  assign decodeError    = err_q;

endmodule
`default_nettype wire
